muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand and result width (legal: 8..64, even).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 flush  input  1  abort the in-flight operation (pipeline squash).
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_op  input  3  muldivop_t: mul, mulh, mulhsu, mulhu, div, divu, rem, remu (RV32M funct3 encoding).
REQ-008 req_a, req_b  input  WIDTH  operands rs1, rs2.
REQ-009 resp_valid  output  1  result present.
REQ-010 resp_ready  input  1  consumer accepts result.
REQ-011 resp_result  output  WIDTH  result.

Function
REQ-012 FSM states SHALL be IDLE, BUSY, DONE only.
REQ-013 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-014 IDLE -> BUSY on acceptance of a normal op; IDLE -> DONE on acceptance of a special-case divide (REQ-020, REQ-021).
REQ-015 BUSY SHALL run exactly WIDTH iterations (one per cycle) then go to DONE; resp_valid first 1 exactly WIDTH+1 cycles after the accept edge; special cases exactly 1 cycle after.
REQ-016 DONE -> IDLE on an edge with resp_ready=1; resp_result and resp_valid SHALL stay stable while resp_ready=0.
REQ-017 Operands and op SHALL be registered at accept; later changes to req_* SHALL not affect the result.
REQ-018 Multiply: radix-2 shift-add on operand magnitudes into a 2*WIDTH product; signed product negated at end when sign(a) xor sign(b) applies; mul returns low WIDTH bits, mulh/mulhsu/mulhu high WIDTH bits; mulhsu treats a signed, b unsigned.
REQ-019 Divide: restoring, one quotient bit per iteration on magnitudes; quotient sign = sign(a) xor sign(b); remainder sign = sign(a) (signed ops only).
REQ-020 Divide by zero: div/divu SHALL return all-ones; rem/remu SHALL return req_a.
REQ-021 Signed overflow (a = most-negative, b = all-ones): div SHALL return most-negative; rem SHALL return 0.
REQ-022 flush=1 in BUSY or DONE SHALL return to IDLE on that edge with no response; flush in IDLE SHALL have no effect, and a request presented with flush=1 SHALL not be accepted.
REQ-023 If flush and resp_ready are both 1 in DONE, flush wins; state still goes to IDLE.
REQ-024 Back-to-back: a new request SHALL be acceptable the cycle after the DONE -> IDLE edge (no combinational ready bypass).
REQ-025 No X SHALL appear on resp_result when resp_valid=1; result otherwise holds last value.

Reset
REQ-026 On a clk edge with rst_n=0: state IDLE, resp_valid 0, resp_result 0, iteration counter 0, all datapath registers 0.
REQ-027 req_ready SHALL be 0 while rst_n=0 and SHALL be 1 on the first cycle after release.
REQ-028 Reset mid-operation SHALL abandon the operation with no response; reset SHALL take priority over flush and the handshake.

Structure
REQ-029 muldivop_t enum and WIDTH default SHALL live in the shared rv32i_types package next to the ALU op enum.
REQ-030 The FSM state enum SHALL be local to the module.
REQ-031 Single module; no sub-module; multiply and divide SHALL share one iteration counter and one accumulator/shift register.
REQ-032 Iteration counter width SHALL be clog2(WIDTH)+1.

Verification (WIDTH=32)
REQ-033 a=b=0xFFFFFFFF: mul -> 0x00000001, mulhu -> 0xFFFFFFFE, mulh -> 0x00000000, mulhsu -> 0xFFFFFFFF; resp_valid at accept+33.
REQ-034 div a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; rem -> 0xFFFFFFFF; divu 100/7 -> 14, remu -> 2.
REQ-035 divu 5/0 -> 0xFFFFFFFF, remu 5/0 -> 5, div 0x80000000/0xFFFFFFFF -> 0x80000000, rem -> 0; each resp_valid at accept+1.
REQ-036 resp_ready held 0 for 5 cycles in DONE -> resp_result constant, req_ready 0; next request accepted the cycle after resp_ready=1.
REQ-037 flush at accept+10 -> IDLE next cycle, no resp_valid; rst_n=0 at accept+20 -> all outputs at reset values, req_ready 1 after release.
REQ-038 Random ops/operands (10k) vs. reference model -> bit-exact match, latency per REQ-015.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32 type definitions: ALU and multiply/divide operation encodings
// plus the default datapath width.
package rv32i_types;

  localparam int MULDIV_WIDTH_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  // RV32M funct3 encoding; bit 2 separates divide from multiply.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldivop_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide sharing one counter and one accumulator/shift register.
module muldiv_unit
  import rv32i_types::*;
#(
  parameter int WIDTH = MULDIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  muldivop_t        req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int ACC_W = 2 * WIDTH + 1;
  localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic neg);
    magnitude = neg ? (~v + ONE_W) : v;
  endfunction

  state_t           state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic [ACC_W-1:0] acc_r, acc_next_s;
  logic [WIDTH-1:0] bmag_r, bmag_next_s;
  muldivop_t        op_r, op_next_s;
  logic             neg_r, neg_next_s;
  logic [WIDTH-1:0] result_r, result_next_s;
  logic             valid_r, valid_next_s;

  logic             accept_s, is_div_s, a_signed_s, b_signed_s, sa_s, sb_s;
  logic             div_zero_s, ovf_s, special_s;
  logic [WIDTH-1:0] special_result_s;

  logic [WIDTH:0]     mul_sum_s, div_diff_s;
  logic [ACC_W-1:0]   mul_step_s, div_shift_s, div_step_s, step_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quot_fix_s, rem_fix_s, final_s;

  assign req_ready   = rst_n && (state_r == ST_IDLE);
  assign accept_s    = req_valid && req_ready && !flush;
  assign resp_valid  = valid_r;
  assign resp_result = result_r;

  // Request decode: operand signedness and the single-cycle divide cases.
  always_comb begin
    is_div_s   = req_op[2];
    a_signed_s = (req_op == MD_MULH) || (req_op == MD_MULHSU) ||
                 (req_op == MD_DIV)  || (req_op == MD_REM);
    b_signed_s = (req_op == MD_MULH) || (req_op == MD_DIV) || (req_op == MD_REM);
    sa_s       = a_signed_s && req_a[WIDTH-1];
    sb_s       = b_signed_s && req_b[WIDTH-1];
    div_zero_s = is_div_s && (req_b == ZERO_W);
    ovf_s      = ((req_op == MD_DIV) || (req_op == MD_REM)) &&
                 (req_a == MOST_NEG) && (req_b == ONES_W);
    special_s  = div_zero_s || ovf_s;
    if (div_zero_s) begin
      special_result_s = ((req_op == MD_DIV) || (req_op == MD_DIVU)) ? ONES_W : req_a;
    end else begin
      special_result_s = (req_op == MD_DIV) ? MOST_NEG : ZERO_W;
    end
  end

  // One iteration of either algorithm plus the sign-corrected final result.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, bmag_r};
    mul_step_s  = acc_r[0] ? ({mul_sum_s, acc_r[WIDTH-1:0]} >> 1) : (acc_r >> 1);
    div_shift_s = acc_r << 1;
    div_diff_s  = div_shift_s[2*WIDTH:WIDTH] - {1'b0, bmag_r};
    // A negative trial difference means the divisor did not fit: restore.
    div_step_s  = div_diff_s[WIDTH] ? div_shift_s
                                    : {div_diff_s, div_shift_s[WIDTH-1:1], 1'b1};
    step_s      = op_r[2] ? div_step_s : mul_step_s;
    prod_fix_s  = neg_r ? (~step_s[2*WIDTH-1:0] + ONE_2W) : step_s[2*WIDTH-1:0];
    quot_fix_s  = magnitude(step_s[WIDTH-1:0], neg_r);
    rem_fix_s   = magnitude(step_s[2*WIDTH-1:WIDTH], neg_r);
    case (op_r)
      MD_MUL:                      final_s = prod_fix_s[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_s = prod_fix_s[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:             final_s = quot_fix_s;
      MD_REM, MD_REMU:             final_s = rem_fix_s;
      default:                     final_s = ZERO_W;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_next_s  = state_r;
    cnt_next_s    = cnt_r;
    acc_next_s    = acc_r;
    bmag_next_s   = bmag_r;
    op_next_s     = op_r;
    neg_next_s    = neg_r;
    result_next_s = result_r;
    valid_next_s  = valid_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          op_next_s   = req_op;
          bmag_next_s = magnitude(req_b, sb_s);
          neg_next_s  = (req_op == MD_REM) ? sa_s : (sa_s ^ sb_s);
          cnt_next_s  = {CNT_W{1'b0}};
          if (special_s) begin
            state_next_s  = ST_DONE;
            result_next_s = special_result_s;
            valid_next_s  = 1'b1;
          end else begin
            state_next_s = ST_BUSY;
            acc_next_s   = {{(WIDTH+1){1'b0}}, magnitude(req_a, sa_s)};
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_next_s = ST_IDLE;
          valid_next_s = 1'b0;
        end else begin
          acc_next_s = step_s;
          cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_ITER) begin
            state_next_s  = ST_DONE;
            result_next_s = final_s;
            valid_next_s  = 1'b1;
          end else begin
            state_next_s = ST_BUSY;
          end
        end
      end
      ST_DONE: begin
        if (flush || resp_ready) begin
          state_next_s = ST_IDLE;
          valid_next_s = 1'b0;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        valid_next_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {ACC_W{1'b0}};
      bmag_r   <= ZERO_W;
      op_r     <= MD_MUL;
      neg_r    <= 1'b0;
      result_r <= ZERO_W;
      valid_r  <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      cnt_r    <= cnt_next_s;
      acc_r    <= acc_next_s;
      bmag_r   <= bmag_next_s;
      op_r     <= op_next_s;
      neg_r    <= neg_next_s;
      result_r <= result_next_s;
      valid_r  <= valid_next_s;
    end
  end

endmodule
